axis_pkt_fifo: RTL and testbench

- Synchronous AXI-Stream FIFO placed directly downstream of the stream mux; it takes the mux's registered 8-bit output stream (data, valid, last) and drives the mux's ready input.
- Absorbs back-pressure bursts from the consumer and tracks how many complete packets (TLAST-terminated) are buffered.
- Output is first-word-fall-through (FWFT): the head entry is always presented on the master side.

---
 rtl/axis_pkg.sv | 16 +
 rtl/axis_fifo_mem.sv | 27 ++
 rtl/axis_pkt_fifo.sv | 114 +++++++++++
 tb/tb_axis_pkt_fifo.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream packet FIFO.
// Beat layout and pointer-width helper used by the FIFO and its bench.
package axis_pkg;

    localparam int AXIS_DATA_W = 8;

    typedef struct packed {
        logic                   last;
        logic [AXIS_DATA_W-1:0] data;
    } axis_beat_t;

    function automatic int axis_clog2(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// FIFO storage: register array, one write port, async read port.
// Storage is deliberately left unreset; the FIFO masks it when empty.
module axis_fifo_mem #(
    parameter int W     = 9,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Write the accepted beat into its slot.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// FWFT AXI-Stream FIFO with packet count and stall watchdog.
// Ready/valid come only from registered pointers; no through paths.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter  int DATA_W = AXIS_DATA_W,
    parameter  int DEPTH  = 16,
    localparam int AW     = axis_clog2(DEPTH)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [DATA_W-1:0] S_TDATA,
    input  logic              S_TVALID,
    input  logic              S_TLAST,
    output logic              S_TREADY,
    output logic [DATA_W-1:0] M_TDATA,
    output logic              M_TVALID,
    output logic              M_TLAST,
    input  logic              M_TREADY,
    output logic [AW:0]       FILL,
    output logic [AW:0]       PKT_CNT,
    output logic              OVF_ERR
);

    localparam logic [AW:0] ONE       = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_V   = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_MAX = (AW+1)'(DEPTH + 1);

    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]     fill_q, fill_d;
    logic [AW:0]     pkt_q, pkt_d;
    logic [AW:0]     stall_q, stall_d;
    logic            ovf_q, ovf_d;
    logic            empty, full, push, pop;
    logic            pkt_inc, pkt_dec;
    logic [DATA_W:0] wr_word, rd_word;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push    = S_TVALID & ~full;
    assign pop     = ~empty & M_TREADY;
    assign wr_word = {S_TLAST, S_TDATA};
    assign pkt_inc = push & S_TLAST;
    assign pkt_dec = pop & rd_word[DATA_W];

    axis_fifo_mem #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (ACLK),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_word),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_word)
    );

    // Next-state for pointers, occupancy, packet count and watchdog.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        pkt_d    = pkt_q;
        stall_d  = '0;
        if (push) wr_ptr_d = wr_ptr_q + ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + ONE;
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + ONE;
            2'b01:   fill_d = fill_q - ONE;
            default: fill_d = fill_q;
        endcase
        unique case ({pkt_inc, pkt_dec})
            2'b10:   pkt_d = pkt_q + ONE;
            2'b01:   pkt_d = pkt_q - ONE;
            default: pkt_d = pkt_q;
        endcase
        if (S_TVALID && full) begin
            stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + ONE;
        end
        ovf_d = ovf_q | (stall_d > DEPTH_V);
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            pkt_q    <= '0;
            stall_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            pkt_q    <= pkt_d;
            stall_q  <= stall_d;
            ovf_q    <= ovf_d;
        end
    end

    assign S_TREADY = ~full;
    assign M_TVALID = ~empty;
    assign M_TDATA  = empty ? '0 : rd_word[DATA_W-1:0];
    assign M_TLAST  = ~empty & rd_word[DATA_W];
    assign FILL     = fill_q;
    assign PKT_CNT  = pkt_q;
    assign OVF_ERR  = ovf_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo.
// Each task drives one scenario and checks against hand-derived values.
module tb_axis_pkt_fifo;
    import axis_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid, s_last, s_ready;
    logic [7:0] m_data;
    logic       m_valid, m_last, m_ready;
    logic [4:0] fill, pkt_cnt;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    axis_pkt_fifo #(.DATA_W(8), .DEPTH(16)) dut (
        .ACLK     (clk),
        .ARESETn  (rst_n),
        .S_TDATA  (s_data),
        .S_TVALID (s_valid),
        .S_TLAST  (s_last),
        .S_TREADY (s_ready),
        .M_TDATA  (m_data),
        .M_TVALID (m_valid),
        .M_TLAST  (m_last),
        .M_TREADY (m_ready),
        .FILL     (fill),
        .PKT_CNT  (pkt_cnt),
        .OVF_ERR  (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mvalid got %b want 0", m_valid);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_sready got %b want 1", s_ready);
        end
        checks++;
        if (fill !== 5'd0) begin
            errors++;
            $display("FAIL reset_fill got %0d want 0", fill);
        end
        checks++;
        if (pkt_cnt !== 5'd0) begin
            errors++;
            $display("FAIL reset_pkt got %0d want 0", pkt_cnt);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b want 0", ovf);
        end
        checks++;
        if (m_data !== 8'h00 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_mask got %h/%b want 00/0", m_data, m_last);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11;
        exp_d[1] = 8'h22;
        exp_d[2] = 8'h33;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h11;
        s_last  = 1'b0;
        step();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h11) begin
            errors++;
            $display("FAIL basic_fwft got %b/%h want 1/11", m_valid, m_data);
        end
        s_data = 8'h22;
        step();
        s_data = 8'h33;
        s_last = 1'b1;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (fill !== 5'd3 || pkt_cnt !== 5'd1) begin
            errors++;
            $display("FAIL basic_fill got %0d/%0d want 3/1", fill, pkt_cnt);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d[i] ||
                m_last !== (i == 2)) begin
                errors++;
                $display("FAIL basic_drain%0d got %b/%h/%b want 1/%h/%b",
                         i, m_valid, m_data, m_last, exp_d[i], i == 2);
            end
            step();
        end
        m_ready = 1'b0;
        checks++;
        if (fill !== 5'd0 || pkt_cnt !== 5'd0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_empty got %0d/%0d/%b want 0/0/0",
                     fill, pkt_cnt, m_valid);
        end
    endtask

    task automatic test_full();
        axis_beat_t exp_b;
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data = 8'(i);
            s_last = (i % 4 == 3);
            step();
        end
        checks++;
        if (s_ready !== 1'b0 || fill !== 5'd16 || pkt_cnt !== 5'd4) begin
            errors++;
            $display("FAIL full_flags got %b/%0d/%0d want 0/16/4",
                     s_ready, fill, pkt_cnt);
        end
        s_data = 8'hAA;
        s_last = 1'b1;
        step();
        checks++;
        if (fill !== 5'd16 || s_ready !== 1'b0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL full_hold got %0d/%b/%h want 16/0/00",
                     fill, s_ready, m_data);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        checks++;
        if (fill !== 5'd15 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pop got %0d/%b want 15/1", fill, s_ready);
        end
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (fill !== 5'd16 || pkt_cnt !== 5'd5 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_refill got %0d/%0d/%b want 16/5/0",
                     fill, pkt_cnt, s_ready);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_b.data = (i < 15) ? 8'(i + 1) : 8'hAA;
            exp_b.last = (i == 15) || ((i + 1) % 4 == 3);
            checks++;
            if (m_data !== exp_b.data || m_last !== exp_b.last) begin
                errors++;
                $display("FAIL full_drain%0d got %h/%b want %h/%b",
                         i, m_data, m_last, exp_b.data, exp_b.last);
            end
            step();
        end
        m_ready = 1'b0;
        checks++;
        if (fill !== 5'd0 || pkt_cnt !== 5'd0) begin
            errors++;
            $display("FAIL full_empty got %0d/%0d want 0/0", fill, pkt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_last  = 1'b0;
        s_data  = 8'h40;
        step();
        for (int i = 1; i < 40; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'(8'h40 + i - 1) ||
                fill !== 5'd1 || s_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream%0d got %b/%h/%0d want 1/%h/1",
                         i, m_valid, m_data, fill, 8'(8'h40 + i - 1));
            end
            s_data = 8'(8'h40 + i);
            step();
        end
        s_valid = 1'b0;
        checks++;
        if (m_data !== 8'h67 || fill !== 5'd1) begin
            errors++;
            $display("FAIL stream_tail got %h/%0d want 67/1", m_data, fill);
        end
        step();
        m_ready = 1'b0;
        checks++;
        if (fill !== 5'd0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end got %0d/%b want 0/0", fill, m_valid);
        end
    endtask

    task automatic test_ovf();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_last  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_data = 8'(8'h80 + i);
            step();
        end
        repeat (16) step();
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_16 got %b want 0", ovf);
        end
        step();
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_17 got %b want 1", ovf);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (16) step();
        m_ready = 1'b0;
        step();
        checks++;
        if (ovf !== 1'b1 || fill !== 5'd0) begin
            errors++;
            $display("FAIL ovf_sticky got %b/%0d want 1/0", ovf, fill);
        end
    endtask

    task automatic test_async_reset();
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 8'(8'hC0 + i);
            s_last = (i == 2);
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (fill !== 5'd5 || pkt_cnt !== 5'd1) begin
            errors++;
            $display("FAIL arst_pre got %0d/%0d want 5/1", fill, pkt_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || s_ready !== 1'b1 ||
            fill !== 5'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL arst_now got %b/%h/%b/%0d/%b want 0/00/1/0/0",
                     m_valid, m_data, s_ready, fill, ovf);
        end
        step();
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if (fill !== 5'd0 || pkt_cnt !== 5'd0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_post got %0d/%0d/%b want 0/0/0",
                     fill, pkt_cnt, m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_ovf();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
